// File: rtl/icdf_req_arbiter.sv
// icdf_req_arbiter: round-robin, credit-limited sharing of one fixed-latency inverse-CDF datapath.
// Optional feature: define ICDF_RANGE_CLAMP_EN to clamp issued samples to [0x0000_0001, 0x0000_FFFF].
module icdf_req_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int LAT   = 4,
    parameter int DEPTH = 8,
    parameter int TW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_u,
    output logic [NREQ-1:0]       req_ready,
    output logic                  dp_valid_in,
    output logic [WIDTH-1:0]      dp_u,
    input  logic                  dp_valid_out,
    input  logic [WIDTH-1:0]      dp_z,
    output logic                  res_valid,
    output logic [WIDTH-1:0]      res_data,
    output logic [TW-1:0]         res_tag,
    input  logic                  res_ready,
    output logic                  err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [TW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    out_q, out_d;
    logic             credit_ok;
    logic [NREQ-1:0]  grant;
    logic [TW-1:0]    gnt_idx;
    logic [TW-1:0]    scan_idx;
    logic             gnt_any;
    logic [WIDTH-1:0] u_arr [NREQ];
    logic [WIDTH-1:0] u_sel, u_iss;

    logic             iss_v_q;
    logic [WIDTH-1:0] iss_u_q;
    logic [TW-1:0]    iss_tag_q;
    logic [LAT-1:0]   tv_q;
    logic [TW-1:0]    tt_q [LAT];

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [TW-1:0]    mem_tag  [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    cnt_q;
    logic             push, pop, mismatch, err_q;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign u_arr[i] = req_u[i*WIDTH +: WIDTH];
    end

    assign credit_ok = (out_q != CW'(DEPTH));

    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        scan_idx = '0;
        ptr_d    = ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = TW'((32'(ptr_q) + k) % NREQ);
            if (!gnt_any && req_valid[scan_idx] && credit_ok) begin
                gnt_any         = 1'b1;
                gnt_idx         = scan_idx;
                grant[scan_idx] = 1'b1;
                ptr_d           = TW'((32'(scan_idx) + 1) % NREQ);
            end
        end
    end

    // Gate with rst_n so the combinational grant reads 0 while reset is held.
    assign req_ready = grant & {NREQ{rst_n}};
    assign u_sel     = u_arr[gnt_idx];

`ifdef ICDF_RANGE_CLAMP_EN
    always_comb begin
        u_iss = u_sel;
        if (u_sel < WIDTH'(32'h0000_0001))
            u_iss = WIDTH'(32'h0000_0001);
        else if (u_sel > WIDTH'(32'h0000_FFFF))
            u_iss = WIDTH'(32'h0000_FFFF);
    end
`else
    assign u_iss = u_sel;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            iss_v_q   <= 1'b0;
            iss_u_q   <= '0;
            iss_tag_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            iss_v_q <= gnt_any;
            if (gnt_any) begin
                iss_u_q   <= u_iss;
                iss_tag_q <= gnt_idx;
            end
        end
    end

    assign dp_valid_in = iss_v_q;
    assign dp_u        = iss_u_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv_q <= '0;
            for (int unsigned k = 0; k < LAT; k++) tt_q[k] <= '0;
        end else begin
            tv_q[0] <= iss_v_q;
            tt_q[0] <= iss_tag_q;
            for (int unsigned k = 1; k < LAT; k++) begin
                tv_q[k] <= tv_q[k-1];
                tt_q[k] <= tt_q[k-1];
            end
        end
    end

    // Untagged results are dropped; a missing result simply leaks its credit.
    assign push     = dp_valid_out & tv_q[LAT-1];
    assign mismatch = dp_valid_out ^ tv_q[LAT-1];
    assign pop      = res_valid & res_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wp_q] <= dp_z;
            mem_tag[wp_q]  <= tt_q[LAT-1];
        end
    end

    always_comb begin
        out_d = out_q;
        case ({gnt_any, pop})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            err_q <= err_q | mismatch;
            if (push) wp_q <= wp_q + AW'(1);
            if (pop)  rp_q <= rp_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign res_valid = (cnt_q != '0);
    assign res_data  = res_valid ? mem_data[rp_q] : '0;
    assign res_tag   = res_valid ? mem_tag[rp_q]  : '0;
    assign err       = err_q;

endmodule

// File: tb/tb_icdf_req_arbiter.sv
// Self-checking bench for icdf_req_arbiter: grant/credit model, latency datapath model and result scoreboard.
module tb_icdf_req_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int TW    = 2;

`ifdef ICDF_RANGE_CLAMP_EN
    localparam logic [WIDTH-1:0] CL_LO = 32'h0000_0001;
    localparam logic [WIDTH-1:0] CL_HI = 32'h0000_FFFF;
`else
    localparam logic [WIDTH-1:0] CL_LO = 32'h0000_0000;
    localparam logic [WIDTH-1:0] CL_HI = 32'h0001_0000;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_u;
    logic [NREQ-1:0]       req_ready;
    logic                  dp_valid_in;
    logic [WIDTH-1:0]      dp_u;
    logic                  dp_valid_out;
    logic [WIDTH-1:0]      dp_z;
    logic                  res_valid;
    logic [WIDTH-1:0]      res_data;
    logic [TW-1:0]         res_tag;
    logic                  res_ready = 1'b0;
    logic                  err;
    logic                  inj = 1'b0;
    logic [WIDTH-1:0]      lane [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign req_u[i*WIDTH +: WIDTH] = lane[i];
    end

    always #5 clk = ~clk;

    icdf_req_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_u(req_u), .req_ready(req_ready),
        .dp_valid_in(dp_valid_in), .dp_u(dp_u), .dp_valid_out(dp_valid_out), .dp_z(dp_z),
        .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag), .res_ready(res_ready),
        .err(err)
    );

    function automatic logic [WIDTH-1:0] fz(input logic [WIDTH-1:0] u);
        return {u[15:0], u[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [WIDTH-1:0] issued(input logic [WIDTH-1:0] u);
`ifdef ICDF_RANGE_CLAMP_EN
        if (u == 32'h0) return 32'h1;
        if (u > 32'h0000_FFFF) return 32'h0000_FFFF;
`endif
        return u;
    endfunction

    // Datapath model: fixed latency LAT, shares rst_n.
    logic [LAT-1:0]   pv;
    logic [WIDTH-1:0] pz [LAT];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int k = 0; k < LAT; k++) pz[k] <= '0;
        end else begin
            pv[0] <= dp_valid_in;
            pz[0] <= fz(dp_u);
            for (int k = 1; k < LAT; k++) begin
                pv[k] <= pv[k-1];
                pz[k] <= pz[k-1];
            end
        end
    end
    assign dp_valid_out = pv[LAT-1] | inj;
    assign dp_z         = pz[LAT-1];

    int unsigned n_cmp = 0, n_err = 0;
    logic [TW+WIDTH-1:0] sb [$];
    int unsigned m_ptr = 0, m_out = 0;
    bit          prev_hs = 0;
    logic [WIDTH-1:0] prev_u = '0;
    int          cyc = 0, first_hs_cyc = -1, first_rv_cyc = -1, last_hs_cyc = 0;
    int unsigned n_hs = 0, n_rv = 0;
    logic        last_dpv = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ptr = 0;
        m_out = 0;
        prev_hs = 0;
    endtask

    task automatic tick();
        logic [NREQ-1:0]     eg;
        int unsigned         gi;
        bit                  found;
        logic [TW+WIDTH-1:0] e;
        @(negedge clk);
        eg = '0; gi = 0; found = 0;
        if (m_out < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                int unsigned j;
                j = (m_ptr + k) % NREQ;
                if (!found && req_valid[j]) begin
                    found = 1; gi = j; eg[j] = 1'b1;
                end
            end
        end
        chk("grant", req_ready, eg);
        chk("dp_valid_in", dp_valid_in, prev_hs);
        if (prev_hs) chk("dp_u", dp_u, prev_u);
        last_dpv = dp_valid_out;
        if (res_valid === 1'b1) begin
            n_rv++;
            if (first_rv_cyc < 0) first_rv_cyc = cyc;
        end
        if (res_valid === 1'b1 && res_ready) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL pop_unexpected: observed tag %0h data %0h expected no result", res_tag, res_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("res_tag", res_tag, e[TW+WIDTH-1:WIDTH]);
                chk("res_data", res_data, e[WIDTH-1:0]);
            end
            if (m_out > 0) m_out--;
        end
        prev_hs = found;
        if (found) begin
            prev_u = issued(lane[gi]);
            sb.push_back({TW'(gi), fz(prev_u)});
            m_ptr = (gi + 1) % NREQ;
            m_out++;
            n_hs++;
            last_hs_cyc = cyc;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        req_valid = '0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        res_ready = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) lane[i] = $urandom;
        req_valid = '1;
        #7;
        chk("reset_state", {req_ready, dp_valid_in, dp_u, res_valid, res_data, res_tag, err}, '0);
        do_reset();

        // Round-robin at full rate
        res_ready = 1'b1;
        req_valid = 4'b1111;
        n_hs = 0; first_hs_cyc = -1; first_rv_cyc = -1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NREQ; i++) lane[i] = $urandom;
            tick();
        end
        req_valid = '0;
        chk("rr_hs_count", n_hs, 8);
        drain("rr_drain");
        chk("round_trip", 32'(first_rv_cyc - first_hs_cyc), LAT + 2);

        // Credit stall on requester 2
        res_ready = 1'b0;
        req_valid = 4'b0100;
        n_hs = 0;
        for (int c = 0; c < 16; c++) begin
            lane[2] = $urandom;
            tick();
        end
        chk("stall_hs_count", n_hs, 8);
        chk("stall_ready", req_ready, 4'b0000);
        res_ready = 1'b1;
        n_hs = 0;
        tick();
        res_ready = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("one_more_grant", n_hs, 1);
        req_valid = '0;

        // Push and pop in the same cycle with a loaded FIFO
        while (cyc < last_hs_cyc + 1 + LAT) tick();
        res_ready = 1'b1;
        tick();
        chk("coincide_dp_valid_out", last_dpv, 1'b1);
        res_ready = 1'b0;
        tick();
        chk("coincide_err", err, 1'b0);
        drain("coincide_drain");

        // Spurious datapath result with empty tag pipe
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("err_set", err, 1'b1);
        chk("err_no_push", res_valid, 1'b0);
        for (int c = 0; c < 3; c++) tick();
        chk("err_hold", err, 1'b1);
        do_reset();
        chk("err_clear", err, 1'b0);

        // Asynchronous reset with requests in flight
        res_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NREQ; i++) lane[i] = $urandom;
            tick();
        end
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {req_ready, dp_valid_in, dp_u, res_valid, res_data, res_tag, err}, '0);
        req_valid = '0;
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_rv = 0;
        for (int c = 0; c < 12; c++) tick();
        chk("no_stale_result", n_rv, 0);

        // Range boundaries of the issued sample
        lane[0] = 32'h0000_0000;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        chk("clamp_lo", dp_u, CL_LO);
        tick();
        lane[0] = 32'h0001_0000;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        chk("clamp_hi", dp_u, CL_HI);
        tick();
        lane[0] = 32'h0000_8000;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        chk("clamp_mid", dp_u, 32'h0000_8000);
        drain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
